depth_resolve: RTL
==================

# depth_resolve

Per-pixel nearest-hit resolver directly downstream of the wall-validity checker. Each cycle it takes one validated hit (enable, pixel index, x/y/z) and keeps, per pixel column, the hit with the smallest depth. A clear sweep at frame start invalidates all columns. A separate read port lets the column renderer fetch the resolved hit per pixel.

## Interface
- NPIX, 640: number of pixel columns; valid pixel index range is 0..NPIX-1.
- AW, 10: address width; 2^AW ≥ NPIX.
- clk  in  1  system clock; one clock domain; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- frame_start  in  1  single-cycle pulse; starts a clear sweep.
- in_en  in  1  hit valid, from the checker's en.
- in_p  in  10  signed pixel index.
- in_x  in  10  signed hit coordinate x.
- in_y  in  10  signed hit coordinate y.
- in_z  in  10  signed hit depth.
- busy  out  1  high while clearing; inputs are ignored while high.
- rd_addr  in  AW  readout pixel index.
- rd_hit  out  1  stored column holds a hit.
- rd_x  out  10  stored x.
- rd_y  out  10  stored y.
- rd_z  out  10  stored z.

## Operation
- Per-column entry: {hit, x[9:0], y[9:0], z[9:0]}, 31 bits.
- States: CLEAR and ACCUM.
- Reset enters CLEAR with clr_addr=0 and flushes the pipeline.
- CLEAR:
  - Each cycle, write {hit=0, x=0, y=0, z=0} to clr_addr, then increment clr_addr.
  - After writing NPIX-1, go to ACCUM.
  - frame_start during CLEAR restarts the sweep at 0.
- ACCUM:
  - frame_start goes to CLEAR, clr_addr=0, and flushes both pipeline stages. No update write occurs after the frame_start cycle.
- Input acceptance: an input is accepted only when in_en=1, in ACCUM, frame_start=0, 0 ≤ in_p < NPIX, and in_z ≥ 0. All other inputs are dropped silently.
- Update rule:
  - If stored hit=0, write {1, in_x, in_y, in_z}.
  - If stored hit=1 and in_z < stored z (signed, strict), replace the entry.
  - Otherwise keep the entry. On equal z, the first hit wins.
- Update pipeline:
  - S0: register the input and issue a synchronous read of the RMW port at in_p.
  - S1: compare with the read data and write if the update rule says so.
- Forwarding: if S1 wrote address A in the previous cycle and the current S1 also targets A, compare against the forwarded written entry, not the stale RAM data. The result must equal strictly sequential processing in arrival order.
- Readout: synchronous read at rd_addr, independent of the update path.
  - No same-cycle bypass: a read in the cycle of a write to the same address returns the old entry.
  - rd_addr ≥ NPIX returns all zeros.
  - While busy=1, rd_hit=0 and the data outputs are 0.

## Timing
- Reset values: busy=1, rd_hit=0, rd_x=rd_y=rd_z=0, state CLEAR, clr_addr=0.
- Clear duration: exactly NPIX cycles. busy falls in the cycle after the last clear write (NPIX+1 edges after rst falls). The first input can be accepted in that cycle.
- Update latency: an input sampled at edge n is written at edge n+1. A readout issued at edge n+2 or later sees the write.
- Throughput: one input per cycle, with no stall and no backpressure.
- Readout latency: 1 cycle, rd_addr at edge n gives data valid after edge n+1.
- busy rises in the cycle after a frame_start edge is sampled.

## Structure
- Shared package maze_pkg holds:
  - NPIX and AW
  - the packed entry typedef (hit, x, y, z)
  - the state enum {CLEAR, ACCUM}
  - the invalid constant 10'h3FF used by the checker
- Sub-module depth_ram: NPIX×31 RAM with one write port and two synchronous read ports (RMW and readout), so it can infer block RAM.
- The top level holds the FSM, the clear counter, S0/S1 registers, the forwarding compare and the readout masking.

## Test plan
- Reset, then wait 640 cycles: busy=1 for exactly 640 cycles. Read addr 5 gives hit=0 and zeros.
- Hits p=3 at z=100, then z=50, then z=50 with different x: final entry is z=50 with the x of the second hit.
- Back-to-back cycles at p=7 with z=200, 150, 180: final z=150. This checks forwarding; z=180 must not overwrite.
- Dropped inputs, with stored addr 0 unchanged in every case:
  - in_en=0
  - in_p=-1 (10'h3FF)
  - in_p=640
  - in_z=-4
  - any input while busy
- frame_start one cycle after a hit at p=9, z=10: the sweep restarts and rd at 9 shows hit=0 after busy falls. frame_start mid-CLEAR at clr_addr=300 extends busy to 640 further cycles.
- Write p=12 with z=40 and readout rd_addr=12 in the same cycle: old entry returned, new entry returned one cycle later.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze renderer pipeline.
package maze_pkg;
  localparam int unsigned NPIX = 640;
  localparam int unsigned AW   = 10;
  localparam logic [9:0] INVALID = 10'h3FF;

  typedef struct packed {
    logic       hit;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] z;
  } entry_t;

  typedef enum logic {CLEAR, ACCUM} state_t;
endpackage

// File: rtl/depth_ram.sv
// Per-column hit store: one write port, two synchronous read ports (RMW and readout).
module depth_ram
  import maze_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] ra_addr,
  output entry_t        ra_data,
  input  logic [AW-1:0] rb_addr,
  output entry_t        rb_data
);
  entry_t mem [NPIX];

  // Read-before-write on both ports: a same-edge read returns the old entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ra_data <= mem[ra_addr];
    rb_data <= mem[rb_addr];
  end
endmodule

// File: rtl/depth_resolve.sv
// Nearest-hit resolver: keeps the smallest non-negative depth per pixel column.
module depth_resolve
  import maze_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          in_en,
  input  logic [9:0]    in_p,
  input  logic [9:0]    in_x,
  input  logic [9:0]    in_y,
  input  logic [9:0]    in_z,
  output logic          busy,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_hit,
  output logic [9:0]    rd_x,
  output logic [9:0]    rd_y,
  output logic [9:0]    rd_z
);
  localparam logic [AW-1:0] NPIX_A = AW'(NPIX);
  localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic          s1_v;
  logic [AW-1:0] s1_addr;
  logic [9:0]    s1_x, s1_y, s1_z;
  logic          wr_v_q;
  logic [AW-1:0] wr_addr_q;
  entry_t        wr_q;
  logic          rd_oob_q;

  logic          accept;
  entry_t        cur, new_e, ra_data, rb_data, wdata;
  logic          upd, we;
  logic [AW-1:0] waddr;

  assign accept = in_en && (state == ACCUM) && !frame_start &&
                  !in_p[9] && (in_p < NPIX_A) && !in_z[9];

  always_comb begin
    // The RAM read for s1 was issued while the previous update was being
    // written, so that write must be forwarded to keep arrival-order semantics.
    cur   = (wr_v_q && (wr_addr_q == s1_addr)) ? wr_q : ra_data;
    new_e = {1'b1, s1_x, s1_y, s1_z};
    upd   = s1_v && !frame_start &&
            (!cur.hit || ($signed(s1_z) < $signed(cur.z)));
    we    = (state == CLEAR) || upd;
    waddr = (state == CLEAR) ? clr_addr : s1_addr;
    wdata = (state == CLEAR) ? '0 : new_e;
  end

  always_ff @(posedge clk) begin
    rd_oob_q <= (rd_addr >= NPIX_A);
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      s1_v     <= 1'b0;
      wr_v_q   <= 1'b0;
    end else begin
      s1_v      <= accept;
      s1_addr   <= in_p;
      s1_x      <= in_x;
      s1_y      <= in_y;
      s1_z      <= in_z;
      wr_v_q    <= upd;
      wr_addr_q <= s1_addr;
      wr_q      <= new_e;
      if (frame_start) begin
        state    <= CLEAR;
        clr_addr <= '0;
        busy     <= 1'b1;
        s1_v     <= 1'b0;
        wr_v_q   <= 1'b0;
      end else if (state == CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == LAST) begin
          state <= ACCUM;
          busy  <= 1'b0;
        end
      end
    end
  end

  depth_ram u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .ra_addr (in_p),
    .ra_data (ra_data),
    .rb_addr (rd_addr),
    .rb_data (rb_data)
  );

  logic rd_ok;
  assign rd_ok  = !busy && !rd_oob_q;
  assign rd_hit = rd_ok & rb_data.hit;
  assign rd_x   = rd_ok ? rb_data.x : '0;
  assign rd_y   = rd_ok ? rb_data.y : '0;
  assign rd_z   = rd_ok ? rb_data.z : '0;
endmodule
